// File: rtl/fetch_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// fetch_mem_arbiter_pkg
// Shared definitions for the fetch/data SRAM arbiter: FSM state encoding and
// default bus widths used by the arbiter and its SRAM interface.
// -----------------------------------------------------------------------------
package fetch_mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    D_BUSY = 2'd1,
    I_BUSY = 2'd2,
    DONE   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/fetch_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// fetch_mem_arbiter_if
// Request/acknowledge bus to the single-ported unified SRAM.
//   sram_req   : request, held high until sram_ack
//   sram_we    : write strobe, qualifies sram_req
//   sram_addr  : word address
//   sram_wdata : write data
//   sram_ack   : one-cycle completion pulse
//   sram_rdata : read data, valid with sram_ack
// Modports: master = arbiter side, slave = memory side.
// -----------------------------------------------------------------------------
interface fetch_mem_arbiter_if
  import fetch_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              sram_req;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic              sram_ack;
  logic [DATA_W-1:0] sram_rdata;

  modport master (
    output sram_req, sram_we, sram_addr, sram_wdata,
    input  sram_ack, sram_rdata
  );

  modport slave (
    input  sram_req, sram_we, sram_addr, sram_wdata,
    output sram_ack, sram_rdata
  );

endinterface

// File: rtl/fetch_mem_arbiter.sv
// -----------------------------------------------------------------------------
// fetch_mem_arbiter
// Shares one single-ported SRAM between the IF stage (fetch every cycle) and
// the MEM-stage data port. Data accesses win whenever the FSM is idle; an
// in-flight fetch is never preempted.
//
// Ports:
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   if_addr_i       : fetch address (PC)
//   if_flush_i      : branch taken, discard in-flight fetch
//   if_instr_o      : fetched instruction (registered)
//   freeze_if_o     : PC must hold; low only in the cycle a fetch result lands
//   dm_rd_en_i      : load request
//   dm_wr_en_i      : store request (wins if both are high)
//   dm_addr_i       : data address
//   dm_wdata_i      : store data
//   dm_rdata_o      : load data (registered)
//   stall_mem_o     : pipeline must hold, data access pending
//   sram            : SRAM request/ack bus (master side)
//
// state  | meaning
// -------+--------------------------------------------------
// IDLE   | nothing outstanding; arbitration happens here
// D_BUSY | data access outstanding
// I_BUSY | fetch outstanding
// DONE   | one-cycle turnaround, completed result presented
// -----------------------------------------------------------------------------
module fetch_mem_arbiter
  import fetch_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_flush_i,
  output logic [DATA_W-1:0] if_instr_o,
  output logic              freeze_if_o,

  input  logic              dm_rd_en_i,
  input  logic              dm_wr_en_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              stall_mem_o,

  fetch_mem_arbiter_if.master sram
);

  arb_state_e        state_q;
  logic              req_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] instr_q;
  logic [DATA_W-1:0] rdata_q;
  logic              abort_q;
  logic              freeze_q;

  logic              dm_req;

  assign dm_req = dm_rd_en_i | dm_wr_en_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      instr_q  <= '0;
      rdata_q  <= '0;
      abort_q  <= 1'b0;
      freeze_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          // The MEM-stage instruction is older, so it always wins here.
          if (dm_req) begin
            state_q <= D_BUSY;
            req_q   <= 1'b1;
            we_q    <= dm_wr_en_i;
            addr_q  <= dm_addr_i;
            wdata_q <= dm_wdata_i;
          end else begin
            state_q <= I_BUSY;
            req_q   <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= if_addr_i;
            abort_q <= 1'b0;
          end
        end

        D_BUSY: begin
          if (sram.sram_ack) begin
            req_q   <= 1'b0;
            state_q <= DONE;
            if (!we_q) begin
              rdata_q <= sram.sram_rdata;
            end
          end
        end

        I_BUSY: begin
          if (if_flush_i) begin
            abort_q <= 1'b1;
          end
          if (sram.sram_ack) begin
            req_q <= 1'b0;
            // A flush in the ack cycle itself must also kill the result,
            // hence the direct if_flush_i term next to abort_q.
            if (!abort_q && !if_flush_i) begin
              instr_q  <= sram.sram_rdata;
              freeze_q <= 1'b0;
              state_q  <= DONE;
            end else begin
              state_q  <= IDLE;
            end
          end
        end

        DONE: begin
          freeze_q <= 1'b1;
          state_q  <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign sram.sram_req   = req_q;
  assign sram.sram_we    = we_q;
  assign sram.sram_addr  = addr_q;
  assign sram.sram_wdata = wdata_q;

  assign if_instr_o  = instr_q;
  assign dm_rdata_o  = rdata_q;
  assign freeze_if_o = freeze_q;

  // Stall already in the IDLE cycle where a data request shows up, so the
  // MEM stage holds before the access is even issued; DONE releases it.
  assign stall_mem_o = (state_q == D_BUSY) || ((state_q == IDLE) && dm_req);

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
module tb_fetch_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] if_addr = '0;
  logic        if_flush = 1'b0;
  logic [31:0] if_instr;
  logic        freeze_if;
  logic        dm_rd_en = 1'b0;
  logic        dm_wr_en = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [31:0] dm_rdata;
  logic        stall_mem;

  int tests = 0;
  int fails = 0;

  int          lat = 2;
  int          cnt = 0;
  logic        late_ack = 1'b0;
  logic [31:0] mem [logic [31:0]];

  fetch_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  fetch_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_addr_i   (if_addr),
    .if_flush_i  (if_flush),
    .if_instr_o  (if_instr),
    .freeze_if_o (freeze_if),
    .dm_rd_en_i  (dm_rd_en),
    .dm_wr_en_i  (dm_wr_en),
    .dm_addr_i   (dm_addr),
    .dm_wdata_i  (dm_wdata),
    .dm_rdata_o  (dm_rdata),
    .stall_mem_o (stall_mem),
    .sram        (bus.master)
  );

  always #5 clk = ~clk;

  // SRAM model: acks in the lat-th cycle that req is high, driven mid-cycle.
  always @(negedge clk) begin
    logic hit;
    hit = 1'b0;
    if (bus.sram_req) begin
      cnt = cnt + 1;
      if (cnt >= lat) begin
        hit = 1'b1;
        cnt = 0;
      end
    end else begin
      cnt = 0;
    end
    bus.sram_ack = hit || late_ack;
    if (late_ack)
      bus.sram_rdata = 32'hFFFF_FFFF;
    else if (mem.exists(bus.sram_addr))
      bus.sram_rdata = mem[bus.sram_addr];
    else
      bus.sram_rdata = 32'h0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    mem[32'h10] = 32'hDEAD_BEEF;
    mem[32'h40] = 32'h0000_1234;
    mem[32'h14] = 32'h1111_1111;
    mem[32'h20] = 32'hBAD0_BAD0;
    mem[32'h30] = 32'h3030_3030;
    mem[32'h44] = 32'h4444_4444;
    mem[32'h50] = 32'h0000_0055;
    for (int i = 0; i < 4; i++) mem[32'h60 + 4*i] = 32'h600D_0000 + i;

    // Reset
    if_addr = 32'h10;
    #1 rst_n = 1'b0;
    #2;
    chk1("rst_req", bus.sram_req, 1'b0);
    chk1("rst_we", bus.sram_we, 1'b0);
    chk("rst_addr", bus.sram_addr, 32'h0);
    chk("rst_wdata", bus.sram_wdata, 32'h0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_rdata", dm_rdata, 32'h0);
    chk1("rst_freeze", freeze_if, 1'b1);
    chk1("rst_stall", stall_mem, 1'b0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    // Idle fetch, k=2
    step();
    chk1("f1_req_c1", bus.sram_req, 1'b1);
    chk("f1_addr", bus.sram_addr, 32'h10);
    chk1("f1_we", bus.sram_we, 1'b0);
    chk1("f1_freeze_c1", freeze_if, 1'b1);
    step();
    chk1("f1_req_c2", bus.sram_req, 1'b1);
    chk1("f1_freeze_c2", freeze_if, 1'b1);
    lat = 1;
    step();
    chk1("f1_req_done", bus.sram_req, 1'b0);
    chk1("f1_freeze_done", freeze_if, 1'b0);
    chk("f1_instr", if_instr, 32'hDEAD_BEEF);
    step();
    chk1("f1_freeze_after", freeze_if, 1'b1);

    // Load wins over pending fetch, k=1
    dm_rd_en = 1'b1;
    dm_addr  = 32'h40;
    #1;
    chk1("ld_stall_idle", stall_mem, 1'b1);
    step();
    chk1("ld_req", bus.sram_req, 1'b1);
    chk("ld_addr", bus.sram_addr, 32'h40);
    chk1("ld_we", bus.sram_we, 1'b0);
    chk1("ld_stall_busy", stall_mem, 1'b1);
    chk1("ld_freeze", freeze_if, 1'b1);
    step();
    chk1("ld_stall_done", stall_mem, 1'b0);
    chk("ld_rdata", dm_rdata, 32'h0000_1234);
    chk1("ld_req_done", bus.sram_req, 1'b0);
    chk1("ld_freeze_done", freeze_if, 1'b1);
    dm_rd_en = 1'b0;
    if_addr  = 32'h14;
    step();
    chk1("ld_idle_stall", stall_mem, 1'b0);
    chk1("ld_idle_req", bus.sram_req, 1'b0);
    step();
    chk1("f2_req", bus.sram_req, 1'b1);
    chk("f2_addr", bus.sram_addr, 32'h14);
    step();
    chk1("f2_freeze", freeze_if, 1'b0);
    chk("f2_instr", if_instr, 32'h1111_1111);

    // Store, k=3
    dm_wr_en = 1'b1;
    dm_addr  = 32'h80;
    dm_wdata = 32'hA5A5_A5A5;
    lat      = 3;
    step();
    chk1("st_stall_idle", stall_mem, 1'b1);
    chk1("st_req_idle", bus.sram_req, 1'b0);
    step();
    chk1("st_req", bus.sram_req, 1'b1);
    chk1("st_we", bus.sram_we, 1'b1);
    chk("st_addr", bus.sram_addr, 32'h80);
    chk("st_wdata_c1", bus.sram_wdata, 32'hA5A5_A5A5);
    dm_wdata = 32'h0;
    step();
    chk("st_wdata_c2", bus.sram_wdata, 32'hA5A5_A5A5);
    chk1("st_stall_c2", stall_mem, 1'b1);
    step();
    chk1("st_req_c3", bus.sram_req, 1'b1);
    chk("st_wdata_c3", bus.sram_wdata, 32'hA5A5_A5A5);
    step();
    chk1("st_req_done", bus.sram_req, 1'b0);
    chk1("st_stall_done", stall_mem, 1'b0);
    chk("st_rdata_kept", dm_rdata, 32'h0000_1234);
    chk1("st_freeze", freeze_if, 1'b1);
    dm_wr_en = 1'b0;
    if_addr  = 32'h20;

    // Flush in second I_BUSY cycle, ack in third
    step();
    step();
    chk1("fl_req", bus.sram_req, 1'b1);
    chk("fl_addr", bus.sram_addr, 32'h20);
    step();
    if_flush = 1'b1;
    if_addr  = 32'h30;
    step();
    if_flush = 1'b0;
    step();
    chk1("fl_req_after", bus.sram_req, 1'b0);
    chk1("fl_freeze", freeze_if, 1'b1);
    chk("fl_instr_kept", if_instr, 32'h1111_1111);
    step();
    chk1("fl_next_req", bus.sram_req, 1'b1);
    chk("fl_next_addr", bus.sram_addr, 32'h30);
    step();
    step();
    step();
    chk1("fl_next_freeze", freeze_if, 1'b0);
    chk("fl_next_instr", if_instr, 32'h3030_3030);

    // Async reset during D_BUSY, then a late ack
    dm_rd_en = 1'b1;
    dm_addr  = 32'h44;
    step();
    chk1("ar_stall_idle", stall_mem, 1'b1);
    step();
    chk1("ar_req", bus.sram_req, 1'b1);
    chk("ar_addr", bus.sram_addr, 32'h44);
    step();
    rst_n    = 1'b0;
    dm_rd_en = 1'b0;
    #1;
    chk1("ar_req_rst", bus.sram_req, 1'b0);
    chk1("ar_we_rst", bus.sram_we, 1'b0);
    chk("ar_addr_rst", bus.sram_addr, 32'h0);
    chk("ar_instr_rst", if_instr, 32'h0);
    chk("ar_rdata_rst", dm_rdata, 32'h0);
    chk1("ar_freeze_rst", freeze_if, 1'b1);
    chk1("ar_stall_rst", stall_mem, 1'b0);
    late_ack = 1'b1;
    if_addr  = 32'h50;
    step();
    late_ack = 1'b0;
    rst_n    = 1'b1;
    step();
    chk1("ar_fetch_req", bus.sram_req, 1'b1);
    chk("ar_fetch_addr", bus.sram_addr, 32'h50);
    chk("ar_late_instr", if_instr, 32'h0);
    chk("ar_late_rdata", dm_rdata, 32'h0);
    step();
    step();
    step();
    chk1("ar_fetch_freeze", freeze_if, 1'b0);
    chk("ar_fetch_instr", if_instr, 32'h0000_0055);

    // Sustained loads, k=1
    lat      = 1;
    dm_rd_en = 1'b1;
    dm_addr  = 32'h60;
    for (int i = 0; i < 4; i++) begin
      step();
      chk1($sformatf("sl%0d_stall_idle", i), stall_mem, 1'b1);
      chk1($sformatf("sl%0d_req_idle", i), bus.sram_req, 1'b0);
      chk1($sformatf("sl%0d_freeze_idle", i), freeze_if, 1'b1);
      step();
      chk1($sformatf("sl%0d_req", i), bus.sram_req, 1'b1);
      chk1($sformatf("sl%0d_we", i), bus.sram_we, 1'b0);
      chk($sformatf("sl%0d_addr", i), bus.sram_addr, 32'h60 + 32'(4*i));
      chk1($sformatf("sl%0d_freeze_busy", i), freeze_if, 1'b1);
      step();
      chk1($sformatf("sl%0d_stall_done", i), stall_mem, 1'b0);
      chk1($sformatf("sl%0d_freeze_done", i), freeze_if, 1'b1);
      chk($sformatf("sl%0d_rdata", i), dm_rdata, 32'h600D_0000 + 32'(i));
      if (i < 3) dm_addr = 32'h60 + 32'(4*(i+1));
      else dm_rd_en = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_mem_arbiter.md
Name: fetch_mem_arbiter

Overview:
- Shares one single-ported unified SRAM between the instruction-fetch stage and the MEM-stage data port of the 5-stage pipeline.
- Sequences each access as a request/acknowledge transaction with variable memory latency.
- Holds the PC register via freeze_if, and the rest of the pipeline via stall_mem, until the owning access completes.
- Data accesses have fixed priority over fetches, because the MEM-stage instruction is older.

Parameters:
- ADDR_W, 32, address width of both requesters and the SRAM.
- DATA_W, 32, instruction/data word width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_addr  in  ADDR_W  fetch address (PC); a fetch is requested every cycle.
- if_flush  in  1  branch taken; any in-flight fetch is discarded.
- if_instr  out  DATA_W  fetched instruction, registered.
- freeze_if  out  1  high: PC must hold, if_instr not valid for this PC.
- dm_rd_en  in  1  MEM-stage load request.
- dm_wr_en  in  1  MEM-stage store request.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_rdata  out  DATA_W  load data, registered.
- stall_mem  out  1  high: pipeline must hold, data access pending.
- sram_req  out  1  memory request, held until ack.
- sram_we  out  1  write strobe, qualifies sram_req.
- sram_addr  out  ADDR_W  memory address.
- sram_wdata  out  DATA_W  memory write data.
- sram_ack  in  1  one-cycle completion pulse; sram_rdata valid in the same cycle.
- sram_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset (rst low, asynchronous) values:
  - state = IDLE
  - sram_req = 0, sram_we = 0, sram_addr = 0, sram_wdata = 0
  - if_instr = 0, dm_rdata = 0
  - abort_flag = 0
  - freeze_if = 1, stall_mem = 0
- Reset mid-transaction abandons the access. The SRAM sees sram_req drop; a late sram_ack arriving in IDLE is ignored.
- States:
  - IDLE: no request outstanding.
  - D_BUSY: data access outstanding.
  - I_BUSY: fetch outstanding.
  - DONE: one-cycle turnaround; completed result is presented.
- IDLE transitions:
  - If dm_rd_en or dm_wr_en: go to D_BUSY. Latch dm_addr/dm_wdata into sram_*, sram_req = 1, sram_we = dm_wr_en.
  - Else: go to I_BUSY. Latch if_addr, sram_req = 1, sram_we = 0, clear abort_flag.
  - If dm_rd_en and dm_wr_en are both high, treat it as a write.
- D_BUSY: sram_* held stable. On sram_ack:
  - Drop sram_req.
  - For a read, capture sram_rdata into dm_rdata.
  - Go to DONE with stall_mem released.
- I_BUSY: sram_* held stable.
  - if_flush in any I_BUSY cycle (including the ack cycle) sets abort_flag.
  - On sram_ack: drop sram_req. If abort_flag is clear and if_flush is low, capture sram_rdata into if_instr and go to DONE (fetch completed). Otherwise discard the data and go to IDLE.
- DONE: lasts 1 cycle, then go to IDLE.
- Output decode:
  - stall_mem = (state == D_BUSY) or (state == IDLE and a data request is present).
  - stall_mem is low in the cycle after ack (DONE), so the MEM stage advances exactly once per access.
  - freeze_if = 0 only in the DONE cycle following a completed, non-aborted fetch. It is 1 in all other cycles, including while the data port owns memory.
- Latency (sram_ack k cycles after sram_req is first high, k ≥ 1):
  - Fetch: k+1 cycles from leaving IDLE to the freeze_if = 0 cycle.
  - Back-to-back fetch throughput: one instruction per k+2 cycles.
- Priority and starvation:
  - Data is evaluated only in IDLE; an in-flight fetch is never preempted.
  - The data requester cannot starve: after any completion the FSM returns to IDLE and data wins.
- if_flush outside I_BUSY has no effect on the arbiter; the PC update is handled by the IF stage.
- No combinational path from sram_ack to sram_req.

Decomposition:
- Shared pipeline package holds the FSM state enum (IDLE, D_BUSY, I_BUSY, DONE) and the ADDR_W/DATA_W defaults.
- Single module; no sub-module is warranted. Output registers are inline.

Test Plan:
- Reset then idle fetch: if_addr = 0x10, SRAM acks 2 cycles after req with 0xDEADBEEF -> sram_req for 2 cycles, if_instr = 0xDEADBEEF, freeze_if low for exactly 1 cycle.
- Load preempts pending fetch: dm_rd_en with dm_addr = 0x40 in IDLE, ack k = 1 with 0x1234 -> data served first, stall_mem high 2 cycles, dm_rdata = 0x1234, then the fetch issues.
- Store: dm_wr_en, addr 0x80, wdata 0xA5A5A5A5 -> sram_we = 1, sram_wdata stable until ack, dm_rdata unchanged.
- Flush mid-fetch: if_flush pulses in the second I_BUSY cycle, ack at cycle 3 -> if_instr keeps its old value, freeze_if stays 1, next fetch uses the new if_addr.
- Async reset asserted during D_BUSY -> all outputs take reset values immediately, before the next clock edge; a late ack is ignored.
- Sustained dm_rd_en for 4 accesses -> four data transactions with a DONE cycle between each; freeze_if stays 1 throughout, no fetch issued.
